// File: rtl/utf8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | utf8_pkg                                                                 |
// | Shared constants, lead-prefix table and helpers for the UTF-8 encoder.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package utf8_pkg;

  localparam logic [31:0] UTF8_REPL_CP = 32'hFFFD;
  localparam logic [31:0] SURR_LO      = 32'hD800;
  localparam logic [31:0] SURR_HI      = 32'hDFFF;
  localparam logic [31:0] UNI_MAX      = 32'h10FFFF;

  // Indexed by sequence length; entries 0 and 1 carry no prefix.
  localparam logic [7:0][7:0] UTF8_LEAD_PFX = {
    8'h00, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h00, 8'h00
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } utf8_state_e;

  function automatic logic [2:0] utf8_len(input logic [31:0] cp);
    if (cp < 32'h80)             return 3'd1;
    else if (cp < 32'h800)       return 3'd2;
    else if (cp < 32'h10000)     return 3'd3;
    else if (cp < 32'h200000)    return 3'd4;
    else if (cp < 32'h4000000)   return 3'd5;
    else                         return 3'd6;
  endfunction

  function automatic logic [7:0] utf8_byte(input logic [31:0] cp,
                                           input logic [2:0]  len,
                                           input logic [2:0]  idx);
    logic [2:0]  k;
    logic [4:0]  sa;
    logic [31:0] sh;
    k  = len - 3'd1 - idx;
    sa = {k, 2'b00} + {1'b0, k, 1'b0};
    sh = cp >> sa;
    if (idx == 3'd0)
      return (len == 3'd1) ? cp[7:0] : (UTF8_LEAD_PFX[len] | sh[7:0]);
    else
      return 8'h80 | {2'b00, sh[5:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/utf8_classify.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | utf8_classify                                                            |
// | Decides replacement and encoded length for one code point.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module utf8_classify
  import utf8_pkg::*;
#(
  parameter bit CHK_RANGE  = 1'b1,
  parameter bit ALLOW_SURR = 1'b0
) (
  input  logic [31:0] i_cp,
  output logic [31:0] o_eff_cp,
  output logic [2:0]  o_len,
  output logic        o_repl
);

  logic w_repl;

  always_comb begin
    w_repl = 1'b0;
    if (i_cp[31])
      w_repl = 1'b1;
    else if (!ALLOW_SURR && (i_cp >= SURR_LO) && (i_cp <= SURR_HI))
      w_repl = 1'b1;
    else if (CHK_RANGE && (i_cp > UNI_MAX))
      w_repl = 1'b1;
  end

  assign o_repl   = w_repl;
  assign o_eff_cp = w_repl ? UTF8_REPL_CP : i_cp;
  assign o_len    = w_repl ? 3'd3 : utf8_len(i_cp);

endmodule
`default_nettype wire

// File: rtl/utf8_stream_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | utf8_stream_encoder                                                      |
// | Serialises one code point per handshake into a UTF-8 byte stream.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module utf8_stream_encoder
  import utf8_pkg::*;
#(
  parameter bit CHK_RANGE  = 1'b1,
  parameter bit ALLOW_SURR = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [31:0]      cp_data,
  input  logic             cp_valid,
  output logic             cp_ready,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             byte_last,
  output logic             replaced,
  output logic [CNT_W-1:0] char_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  utf8_state_e      r_state;
  logic [31:0]      r_cp;
  logic [2:0]       r_len;
  logic [2:0]       r_idx;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid;
  logic             r_byte_last;
  logic             r_replaced;
  logic [CNT_W-1:0] r_char_count;
  logic [CNT_W-1:0] r_err_count;

  logic [31:0]      w_eff_cp;
  logic [2:0]       w_len;
  logic             w_repl;
  logic             w_cp_ready;
  logic             w_cp_accept;
  logic             w_byte_accept;
  logic [2:0]       w_idx_nxt;

  utf8_classify #(
    .CHK_RANGE  (CHK_RANGE),
    .ALLOW_SURR (ALLOW_SURR)
  ) u_classify (
    .i_cp     (cp_data),
    .o_eff_cp (w_eff_cp),
    .o_len    (w_len),
    .o_repl   (w_repl)
  );

  // Last byte leaving frees the holding register in the same cycle.
  assign w_cp_ready    = (r_state == ST_IDLE) | (r_byte_valid & byte_ready & r_byte_last);
  assign w_cp_accept   = cp_valid & w_cp_ready;
  assign w_byte_accept = r_byte_valid & byte_ready;
  assign w_idx_nxt     = r_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      r_state      <= ST_IDLE;
      r_cp         <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_byte_last  <= 1'b0;
      r_replaced   <= 1'b0;
      r_char_count <= '0;
      r_err_count  <= '0;
    end else begin
      r_replaced <= 1'b0;
      if (w_cp_accept) begin
        r_state      <= ST_EMIT;
        r_cp         <= w_eff_cp;
        r_len        <= w_len;
        r_idx        <= 3'd0;
        r_byte_data  <= utf8_byte(w_eff_cp, w_len, 3'd0);
        r_byte_valid <= 1'b1;
        r_byte_last  <= (w_len == 3'd1);
        r_replaced   <= w_repl;
        if (r_char_count != c_CNT_MAX)
          r_char_count <= r_char_count + c_CNT_ONE;
        if (w_repl && (r_err_count != c_CNT_MAX))
          r_err_count <= r_err_count + c_CNT_ONE;
      end else if (w_byte_accept) begin
        if (r_byte_last) begin
          r_state      <= ST_IDLE;
          r_byte_valid <= 1'b0;
          r_byte_last  <= 1'b0;
        end else begin
          r_idx       <= w_idx_nxt;
          r_byte_data <= utf8_byte(r_cp, r_len, w_idx_nxt);
          r_byte_last <= (w_idx_nxt == (r_len - 3'd1));
        end
      end
    end
  end

  assign cp_ready   = w_cp_ready;
  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign byte_last  = r_byte_last;
  assign replaced   = r_replaced;
  assign char_count = r_char_count;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_utf8_stream_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_utf8_stream_encoder                                                   |
// | Directed and random checks of the encoder against a byte-list model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_utf8_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] cp_data = '0;
  logic        cp_valid = 1'b0;
  logic        byte_ready = 1'b0;
  int          sel = 0;

  logic        a_cp_ready, a_byte_valid, a_byte_last, a_replaced;
  logic [7:0]  a_byte_data;
  logic [15:0] a_char_count, a_err_count;
  logic        b_cp_ready, b_byte_valid, b_byte_last, b_replaced;
  logic [7:0]  b_byte_data;
  logic [15:0] b_char_count, b_err_count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] cc[2];
  logic [15:0] ec[2];

  always #5 clk = ~clk;

  // Instance a: range checked. Instance b: legacy 5/6-byte forms allowed.
  utf8_stream_encoder #(.CHK_RANGE(1'b1), .ALLOW_SURR(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst_in(rst_in), .cp_data(cp_data), .cp_valid(cp_valid & (sel == 0)),
    .cp_ready(a_cp_ready), .byte_data(a_byte_data), .byte_valid(a_byte_valid),
    .byte_ready(byte_ready), .byte_last(a_byte_last), .replaced(a_replaced),
    .char_count(a_char_count), .err_count(a_err_count));

  utf8_stream_encoder #(.CHK_RANGE(1'b0), .ALLOW_SURR(1'b0), .CNT_W(16)) dut_l (
    .clk(clk), .rst_in(rst_in), .cp_data(cp_data), .cp_valid(cp_valid & (sel == 1)),
    .cp_ready(b_cp_ready), .byte_data(b_byte_data), .byte_valid(b_byte_valid),
    .byte_ready(byte_ready), .byte_last(b_byte_last), .replaced(b_replaced),
    .char_count(b_char_count), .err_count(b_err_count));

  wire        o_rdy  = sel ? b_cp_ready   : a_cp_ready;
  wire [7:0]  o_dat  = sel ? b_byte_data  : a_byte_data;
  wire        o_vld  = sel ? b_byte_valid : a_byte_valid;
  wire        o_lst  = sel ? b_byte_last  : a_byte_last;
  wire        o_rep  = sel ? b_replaced   : a_replaced;
  wire [15:0] o_ccnt = sel ? b_char_count : a_char_count;
  wire [15:0] o_ecnt = sel ? b_err_count  : a_err_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Model: replace bad scalars, then peel 6-bit groups from the low end.
  task automatic ref_encode(input logic [31:0] cp, input bit range_chk,
                            output logic [7:0] b[6], output int n, output bit repl);
    logic [31:0] v;
    logic [7:0]  m;
    repl = (cp >= 32'h8000_0000) || (cp >= 32'hD800 && cp <= 32'hDFFF) ||
           (range_chk && cp > 32'h10FFFF);
    v = repl ? 32'hFFFD : cp;
    n = (v < 32'h80) ? 1 : (v < 32'h800) ? 2 : (v < 32'h10000) ? 3 :
        (v < 32'h200000) ? 4 : (v < 32'h4000000) ? 5 : 6;
    for (int i = 0; i < 6; i++) b[i] = 8'h00;
    if (n == 1) begin
      b[0] = v[7:0];
    end else begin
      for (int i = n - 1; i >= 1; i--) begin
        b[i] = 8'h80 | 8'(v % 64);
        v = v / 64;
      end
      m = 8'hFF << (8 - n);
      b[0] = m | v[7:0];
    end
  endtask

  task automatic send(input logic [31:0] cp, input int stall_at, input int stall_n,
                      input bit rnd);
    logic [7:0] eb[6];
    int         n;
    int         ns;
    bit         er;
    bit         pulse_done;
    ref_encode(cp, (sel == 0), eb, n, er);
    cc[sel] = cc[sel] + 16'd1;
    if (er) ec[sel] = ec[sel] + 16'd1;
    pulse_done = 1'b0;
    cp_data = cp; cp_valid = 1'b1; byte_ready = 1'b0;
    settle();
    chk("cp_ready_idle", {31'd0, o_rdy}, 32'd1);
    tick();
    cp_valid = 1'b0; cp_data = $urandom;
    settle();
    chk("first_valid", {31'd0, o_vld}, 32'd1);
    chk("replaced", {31'd0, o_rep}, {31'd0, er});
    chk("char_count", {16'd0, o_ccnt}, {16'd0, cc[sel]});
    chk("err_count", {16'd0, o_ecnt}, {16'd0, ec[sel]});
    for (int i = 0; i < n; i++) begin
      ns = rnd ? int'($urandom_range(0, 2)) : ((i == stall_at) ? stall_n : 0);
      for (int s = 0; s < ns; s++) begin
        byte_ready = 1'b0;
        settle();
        chk("stall_data", {24'd0, o_dat}, {24'd0, eb[i]});
        chk("stall_cp_ready", {31'd0, o_rdy}, 32'd0);
        tick();
        if (!pulse_done) begin
          chk("replaced_pulse", {31'd0, o_rep}, 32'd0);
          pulse_done = 1'b1;
        end
      end
      byte_ready = 1'b1;
      settle();
      chk("byte_data", {24'd0, o_dat}, {24'd0, eb[i]});
      chk("byte_valid", {31'd0, o_vld}, 32'd1);
      chk("byte_last", {31'd0, o_lst}, {31'd0, (i == n - 1)});
      chk("cp_ready_busy", {31'd0, o_rdy}, {31'd0, (i == n - 1)});
      tick();
      if (!pulse_done) begin
        chk("replaced_pulse", {31'd0, o_rep}, 32'd0);
        pulse_done = 1'b1;
      end
    end
    byte_ready = 1'b0;
    settle();
    chk("idle_after", {31'd0, o_vld}, 32'd0);
  endtask

  initial begin
    logic [31:0] rcp;
    cc[0] = '0; cc[1] = '0; ec[0] = '0; ec[1] = '0;

    // Reset state
    rst_in = 1'b0;
    tick(); tick();
    rst_in = 1'b1;
    settle();
    chk("rst_valid", {31'd0, o_vld}, 32'd0);
    chk("rst_data", {24'd0, o_dat}, 32'd0);
    chk("rst_last", {31'd0, o_lst}, 32'd0);
    chk("rst_repl", {31'd0, o_rep}, 32'd0);
    chk("rst_ccnt", {16'd0, o_ccnt}, 32'd0);
    chk("rst_ecnt", {16'd0, o_ecnt}, 32'd0);
    chk("rst_ready", {31'd0, o_rdy}, 32'd1);

    // Back-to-back single-byte characters
    cp_data = 32'h41; cp_valid = 1'b1; byte_ready = 1'b1;
    tick();
    settle();
    chk("b2b_first", {24'd0, o_dat}, 32'h41);
    chk("b2b_first_last", {31'd0, o_lst}, 32'd1);
    chk("b2b_ready", {31'd0, o_rdy}, 32'd1);
    cp_data = 32'h42;
    tick();
    cp_valid = 1'b0;
    settle();
    chk("b2b_second", {24'd0, o_dat}, 32'h42);
    chk("b2b_second_last", {31'd0, o_lst}, 32'd1);
    chk("b2b_ccnt", {16'd0, o_ccnt}, 32'd2);
    tick();
    byte_ready = 1'b0;
    settle();
    chk("b2b_idle", {31'd0, o_vld}, 32'd0);
    cc[0] = 16'd2;

    // Directed encodings and replacements
    send(32'h20AC, 1, 3, 1'b0);
    send(32'h1F600, 0, 0, 1'b0);
    send(32'h7FF, 0, 0, 1'b0);
    send(32'hD800, 0, 0, 1'b0);
    send(32'h110000, 2, 1, 1'b0);
    sel = 1;
    send(32'h110000, 0, 0, 1'b0);
    send(32'h8000_0000, 0, 0, 1'b0);
    send(32'h7FFF_FFFF, 3, 2, 1'b0);
    send(32'h0400_0000, 0, 0, 1'b0);
    sel = 0;

    // Reset mid-sequence drops the character in flight
    cp_data = 32'h10FFFF; cp_valid = 1'b1; byte_ready = 1'b0;
    tick();
    cp_valid = 1'b0; byte_ready = 1'b1;
    settle();
    chk("mid_b0", {24'd0, o_dat}, 32'hF4);
    tick();
    settle();
    chk("mid_b1", {24'd0, o_dat}, 32'h8F);
    tick();
    rst_in = 1'b0; byte_ready = 1'b0;
    tick();
    rst_in = 1'b1;
    settle();
    chk("mid_rst_valid", {31'd0, o_vld}, 32'd0);
    chk("mid_rst_ccnt", {16'd0, o_ccnt}, 32'd0);
    chk("mid_rst_ecnt", {16'd0, o_ecnt}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_rdy}, 32'd1);
    cc[0] = '0; cc[1] = '0; ec[0] = '0; ec[1] = '0;
    send(32'h41, 0, 0, 1'b0);

    // Random code points across every length and replacement class
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rcp = $urandom_range(0, 32'h7F);
        1: rcp = $urandom_range(32'h80, 32'h7FF);
        2: rcp = $urandom_range(32'h800, 32'hFFFF);
        3: rcp = $urandom_range(32'hD800, 32'hDFFF);
        4: rcp = $urandom_range(32'h10000, 32'h10FFFF);
        5: rcp = $urandom_range(32'h110000, 32'h3FFFFFF);
        6: rcp = $urandom_range(32'h4000000, 32'h7FFFFFFF);
        default: rcp = $urandom | 32'h8000_0000;
      endcase
      send(rcp, 0, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
